// File: rtl/dm_pkg.sv
// Shared definitions for the debug-module SBA to TL-UL bridge:
// TL-UL opcode encodings and the host-port FSM state encoding.
package dm_pkg;

  localparam logic [2:0] TlGet            = 3'd4;
  localparam logic [2:0] TlPutFullData    = 3'd0;
  localparam logic [2:0] TlPutPartialData = 3'd1;
  localparam logic [2:0] TlAccessAck      = 3'd0;
  localparam logic [2:0] TlAccessAckData  = 3'd1;

  typedef enum logic {
    Idle        = 1'b0,
    Outstanding = 1'b1
  } sba_state_e;

endpackage

// File: rtl/dm_sba_tlul_host.sv
// Bridges the SBA req/gnt/r_valid master port onto a TL-UL host port with a
// single outstanding transaction and a bounded wait for the D response.
module dm_sba_tlul_host
  import dm_pkg::*;
#(
  parameter int unsigned        BusWidth      = 32,
  parameter int unsigned        SourceW       = 8,
  parameter logic [SourceW-2:0] SourceBase    = '0,
  parameter int unsigned        TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic                  master_req_i,
  input  logic [BusWidth-1:0]   master_add_i,
  input  logic                  master_we_i,
  input  logic [BusWidth-1:0]   master_wdata_i,
  input  logic [BusWidth/8-1:0] master_be_i,
  output logic                  master_gnt_o,
  output logic                  master_r_valid_o,
  output logic [BusWidth-1:0]   master_r_rdata_o,
  output logic                  master_r_err_o,
  output logic                  tl_a_valid_o,
  output logic [2:0]            tl_a_opcode_o,
  output logic [1:0]            tl_a_size_o,
  output logic [SourceW-1:0]    tl_a_source_o,
  output logic [BusWidth-1:0]   tl_a_address_o,
  output logic [BusWidth/8-1:0] tl_a_mask_o,
  output logic [BusWidth-1:0]   tl_a_data_o,
  input  logic                  tl_a_ready_i,
  input  logic                  tl_d_valid_i,
  input  logic [2:0]            tl_d_opcode_i,
  input  logic [SourceW-1:0]    tl_d_source_i,
  input  logic [BusWidth-1:0]   tl_d_data_i,
  input  logic                  tl_d_error_i,
  output logic                  tl_d_ready_o
);

  localparam int unsigned BeW  = BusWidth / 8;
  localparam int unsigned OffW = $clog2(BeW);
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast =
    (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);

  sba_state_e      state_q, state_d;
  logic            tag_q, tag_d;
  logic            we_q, we_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            match;
  logic            timeout_hit;
  logic            opcode_bad;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      tag_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tl_a_size_o  = 2'(OffW);
  assign tl_d_ready_o = 1'b1;

  // The tag cannot change while Outstanding, so it doubles as the expected tag.
  assign match       = tl_d_valid_i && (tl_d_source_i == {SourceBase, tag_q});
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);
  assign opcode_bad  = we_q ? (tl_d_opcode_i != TlAccessAck)
                            : (tl_d_opcode_i != TlAccessAckData);

  always_comb begin
    state_d          = state_q;
    tag_d            = tag_q;
    we_d             = we_q;
    cnt_d            = cnt_q;
    master_gnt_o     = 1'b0;
    master_r_valid_o = 1'b0;
    master_r_rdata_o = '0;
    master_r_err_o   = 1'b0;
    tl_a_valid_o     = 1'b0;
    tl_a_opcode_o    = 3'd0;
    tl_a_source_o    = '0;
    tl_a_address_o   = '0;
    tl_a_mask_o      = '0;
    tl_a_data_o      = '0;

    unique case (state_q)
      Idle: begin
        tl_a_valid_o = master_req_i && dmactive_i;
        if (tl_a_valid_o) begin
          tl_a_source_o  = {SourceBase, tag_q};
          tl_a_address_o = master_add_i & ~BusWidth'(BeW - 1);
          tl_a_data_o    = master_wdata_i;
          if (master_we_i) begin
            tl_a_opcode_o = (&master_be_i) ? TlPutFullData : TlPutPartialData;
            tl_a_mask_o   = master_be_i;
          end else begin
            tl_a_opcode_o = TlGet;
            tl_a_mask_o   = '1;
          end
          master_gnt_o = tl_a_ready_i;
          if (tl_a_ready_i) begin
            state_d = Outstanding;
            cnt_d   = '0;
            we_d    = master_we_i;
          end
        end
      end

      Outstanding: begin
        if (!dmactive_i) begin
          // Silent abort; toggling the tag turns any late response into a stray.
          state_d = Idle;
          tag_d   = ~tag_q;
        end else if (match) begin
          master_r_valid_o = 1'b1;
          master_r_rdata_o = (tl_d_opcode_i == TlAccessAckData) ? tl_d_data_i : '0;
          master_r_err_o   = tl_d_error_i || opcode_bad;
          state_d          = Idle;
          tag_d            = ~tag_q;
        end else if (timeout_hit) begin
          master_r_valid_o = 1'b1;
          master_r_err_o   = 1'b1;
          state_d          = Idle;
          tag_d            = ~tag_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = Idle;
    endcase
  end

endmodule

// File: tb/tb_dm_sba_tlul_host.sv
// Scoreboard bench for dm_sba_tlul_host: expected SBA responses are queued as D
// responses (or timeouts) are provoked and compared when r_valid pulses.
module tb_dm_sba_tlul_host;

  localparam logic [6:0] SrcBase = 7'h05;
  localparam logic [7:0] Src0    = {SrcBase, 1'b0};
  localparam logic [7:0] Src1    = {SrcBase, 1'b1};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmactive, req, we, a_ready;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic        gnt, r_valid, r_err;
  logic [31:0] rdata;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_error, d_ready;
  logic [2:0]  d_opcode;
  logic [7:0]  d_source;
  logic [31:0] d_data;

  resp_t sb[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    rv_cnt = 0;
  int    cyc = 0;
  int    last_rv_cyc = 0;
  int    gnt_cyc = 0;
  int    rv0 = 0;

  dm_sba_tlul_host #(
    .BusWidth     (32),
    .SourceW      (8),
    .SourceBase   (SrcBase),
    .TimeoutCycles(8)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .dmactive_i      (dmactive),
    .master_req_i    (req),
    .master_add_i    (add),
    .master_we_i     (we),
    .master_wdata_i  (wdata),
    .master_be_i     (be),
    .master_gnt_o    (gnt),
    .master_r_valid_o(r_valid),
    .master_r_rdata_o(rdata),
    .master_r_err_o  (r_err),
    .tl_a_valid_o    (a_valid),
    .tl_a_opcode_o   (a_opcode),
    .tl_a_size_o     (a_size),
    .tl_a_source_o   (a_source),
    .tl_a_address_o  (a_address),
    .tl_a_mask_o     (a_mask),
    .tl_a_data_o     (a_data),
    .tl_a_ready_i    (a_ready),
    .tl_d_valid_i    (d_valid),
    .tl_d_opcode_i   (d_opcode),
    .tl_d_source_i   (d_source),
    .tl_d_data_i     (d_data),
    .tl_d_error_i    (d_error),
    .tl_d_ready_o    (d_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Response monitor: every r_valid pulse must consume one queued expectation.
  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      rv_cnt++;
      last_rv_cyc = cyc;
      chk("rv_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        resp_t e;
        e = sb.pop_front();
        chk("r_rdata", rdata, e.rdata);
        chk("r_err", 32'(r_err), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [3:0] b);
    req = 1'b1; add = a; we = w; wdata = wd; be = b;
  endtask

  task automatic check_a(input logic [2:0] op, input logic [31:0] adr,
                         input logic [3:0] msk, input logic [7:0] src,
                         input logic [31:0] dat);
    chk("a_valid", 32'(a_valid), 1);
    chk("a_opcode", 32'(a_opcode), 32'(op));
    chk("a_address", a_address, adr);
    chk("a_mask", 32'(a_mask), 32'(msk));
    chk("a_source", 32'(a_source), 32'(src));
    chk("a_data", a_data, dat);
  endtask

  task automatic send_d(input logic [2:0] op, input logic [7:0] src,
                        input logic [31:0] dat, input logic e);
    d_valid = 1'b1; d_opcode = op; d_source = src; d_data = dat; d_error = e;
    step();
    d_valid = 1'b0; d_opcode = 3'd0; d_source = 8'd0; d_data = 32'd0; d_error = 1'b0;
  endtask

  task automatic push(input logic [31:0] r, input logic e);
    resp_t x;
    x.rdata = r;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_valid"}, 32'(a_valid), 0);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_r_valid"}, 32'(r_valid), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_r_err"}, 32'(r_err), 0);
    chk({tag, "_d_ready"}, 32'(d_ready), 1);
    chk({tag, "_a_size"}, 32'(a_size), 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dmactive = 1'b1; req = 1'b0; we = 1'b0; add = '0; wdata = '0;
    be = '0; a_ready = 1'b1; d_valid = 1'b0; d_opcode = '0; d_source = '0;
    d_data = '0; d_error = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    step(); step();
    rst_n = 1'b1;
    step();

    // Read with same-cycle grant, response two cycles later
    drive_req(32'h1000_0006, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    chk("rd_gnt", 32'(gnt), 1);
    check_a(3'd4, 32'h1000_0004, 4'hF, Src0, 32'h0);
    step();
    @(negedge clk);
    chk("out_a_valid", 32'(a_valid), 0);
    chk("out_gnt", 32'(gnt), 0);
    step();
    req = 1'b0;
    push(32'hDEAD_BEEF, 1'b0);
    send_d(3'd1, Src0, 32'hDEAD_BEEF, 1'b0);

    // Full write; AccessAck carries junk data that must not leak
    drive_req(32'h2000_0010, 1'b1, 32'h1234_5678, 4'hF);
    @(negedge clk);
    chk("wf_gnt", 32'(gnt), 1);
    check_a(3'd0, 32'h2000_0010, 4'hF, Src1, 32'h1234_5678);
    step();
    req = 1'b0;
    push(32'h0, 1'b0);
    send_d(3'd0, Src1, 32'h5555_5555, 1'b0);

    // Partial write answered with d_error
    drive_req(32'h2000_0003, 1'b1, 32'hA5A5_0000, 4'h3);
    @(negedge clk);
    chk("wp_gnt", 32'(gnt), 1);
    check_a(3'd1, 32'h2000_0000, 4'h3, Src0, 32'hA5A5_0000);
    step();
    req = 1'b0;
    push(32'h0, 1'b1);
    send_d(3'd0, Src0, 32'h0, 1'b1);

    // Backpressure for three cycles, then a stray, then a read answered by AccessAck
    a_ready = 1'b0;
    drive_req(32'h3000_0008, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_gnt", 32'(gnt), 0);
      check_a(3'd4, 32'h3000_0008, 4'hF, Src1, 32'h0);
      step();
    end
    a_ready = 1'b1;
    @(negedge clk);
    chk("bp_gnt_rdy", 32'(gnt), 1);
    step();
    req = 1'b0;
    rv0 = rv_cnt;
    send_d(3'd1, Src0, 32'hBAD0_BAD0, 1'b0);
    chk("stray_dropped", 32'(rv_cnt - rv0), 0);
    req = 1'b1;
    @(negedge clk);
    chk("stray_still_out", 32'(a_valid), 0);
    req = 1'b0;
    step();
    push(32'h0, 1'b1);
    send_d(3'd0, Src1, 32'hCAFE_F00D, 1'b0);

    // Timeout after 8 cycles, then a late response under the old tag
    drive_req(32'h5000_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    chk("to_gnt", 32'(gnt), 1);
    gnt_cyc = cyc;
    step();
    req = 1'b0;
    push(32'h0, 1'b1);
    rv0 = rv_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rv_cnt != rv0) break;
    end
    chk("to_seen", 32'(rv_cnt - rv0), 1);
    chk("to_latency", 32'(last_rv_cyc - gnt_cyc), 8);
    step();
    rv0 = rv_cnt;
    send_d(3'd1, Src0, 32'h9999_9999, 1'b0);
    chk("late_dropped", 32'(rv_cnt - rv0), 0);

    // Back-to-back: new grant in the cycle after r_valid
    drive_req(32'h0000_0040, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    chk("b2b_gnt1", 32'(gnt), 1);
    chk("b2b_src1", 32'(a_source), 32'(Src1));
    step();
    push(32'h1111_1111, 1'b0);
    d_valid = 1'b1; d_opcode = 3'd1; d_source = Src1; d_data = 32'h1111_1111;
    @(negedge clk);
    chk("b2b_no_gnt", 32'(gnt), 0);
    step();
    d_valid = 1'b0; d_opcode = 3'd0; d_source = 8'd0; d_data = 32'd0;
    @(negedge clk);
    chk("b2b_gnt2", 32'(gnt), 1);
    chk("b2b_src2", 32'(a_source), 32'(Src0));
    step();
    req = 1'b0;

    // dmactive abort while Outstanding, then blocked in Idle
    dmactive = 1'b0;
    rv0 = rv_cnt;
    @(negedge clk);
    chk("abort_a_valid", 32'(a_valid), 0);
    step();
    req = 1'b1;
    @(negedge clk);
    chk("inact_a_valid", 32'(a_valid), 0);
    chk("inact_gnt", 32'(gnt), 0);
    step();
    chk("abort_no_rv", 32'(rv_cnt - rv0), 0);
    dmactive = 1'b1;
    @(negedge clk);
    chk("react_gnt", 32'(gnt), 1);
    chk("react_src", 32'(a_source), 32'(Src1));
    step();
    req = 1'b0;

    // Asynchronous reset mid-transaction with a matching response on the wire
    rst_n = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd1; d_source = Src1; d_data = 32'h7777_7777;
    #1;
    check_reset_outputs("arst");
    step();
    d_valid = 1'b0; d_opcode = 3'd0; d_source = 8'd0; d_data = 32'd0;
    rst_n = 1'b1;
    step();
    drive_req(32'h8000_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 1);
    chk("post_rst_src", 32'(a_source), 32'(Src0));
    step();
    req = 1'b0;
    push(32'hABCD_0123, 1'b0);
    send_d(3'd1, Src0, 32'hABCD_0123, 1'b0);

    step(); step();
    chk("rv_total", 32'(rv_cnt), 7);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_sba_tlul_host.md
Name: dm_sba_tlul_host

Overview:
- Downstream bridge for the debug module's system-bus-access (SBA) master port.
- Converts the SBA simple req/gnt/r_valid master interface into a TL-UL host port (A/D channels, flattened signals).
- Allows exactly one outstanding transaction and bounds the wait with a response timeout.
- Sits between the SBA engine and the crossbar host port.

Parameters:
- BusWidth, 32, data/address width in bits; 32 or 64 only.
- SourceBase, 0, upper bits of a_source; width SourceW-1.
- SourceW, 8, TL-UL source ID width.
- TimeoutCycles, 1024, cycles to wait for a D response before aborting; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  debug module active; low aborts and blocks requests
- master_req_i  in  1  SBA request
- master_add_i  in  BusWidth  byte address
- master_we_i  in  1  write enable
- master_wdata_i  in  BusWidth  write data
- master_be_i  in  BusWidth/8  byte enables
- master_gnt_o  out  1  request accepted
- master_r_valid_o  out  1  response pulse (read data or write ack)
- master_r_rdata_o  out  BusWidth  read data
- master_r_err_o  out  1  response error, qualified by r_valid
- tl_a_valid_o  out  1  A-channel valid
- tl_a_opcode_o  out  3  Get=4, PutFullData=0, PutPartialData=1
- tl_a_size_o  out  2  log2(BusWidth/8)
- tl_a_source_o  out  SourceW  {SourceBase, tag}
- tl_a_address_o  out  BusWidth  bus-aligned address
- tl_a_mask_o  out  BusWidth/8  byte mask
- tl_a_data_o  out  BusWidth  write data
- tl_a_ready_i  in  1  A-channel ready
- tl_d_valid_i  in  1  D-channel valid
- tl_d_opcode_i  in  3  AccessAck=0, AccessAckData=1
- tl_d_source_i  in  SourceW  response source
- tl_d_data_i  in  BusWidth  response data
- tl_d_error_i  in  1  response error
- tl_d_ready_o  out  1  D-channel ready

Behaviour:
- Clock clk_i; reset rst_ni, asynchronous, active-low.
- Reset values: state=Idle, tag=0, timeout counter=0. All outputs are 0, except tl_d_ready_o=1 and tl_a_size_o=log2(BusWidth/8).
- States:
  - Idle: tl_a_valid_o = master_req_i & dmactive_i.
  - Outstanding: tl_a_valid_o = 0.
- A-channel field encoding:
  - Address: master_add_i with the low log2(BusWidth/8) bits zeroed.
  - Write opcode: PutFullData when be is all ones, otherwise PutPartialData; mask=be.
  - Read opcode: Get; mask all ones.
  - a_data = wdata.
  - All A fields are combinational from the inputs while a_valid is high.
- Grant: master_gnt_o = tl_a_valid_o & tl_a_ready_i, in the same cycle.
  - On gnt: go to Outstanding, clear the counter, latch the current tag as the expected tag.
- D channel: tl_d_ready_o=1 in every state, so stray responses are always drained.
- A response matches when d_valid and d_source == {SourceBase, expected tag}.
- In Outstanding, a matching response in cycle N:
  - master_r_valid_o=1 in cycle N, combinational.
  - rdata = d_data for AccessAckData, otherwise 0.
  - err = d_error | (opcode inconsistent with the request type).
  - Next state Idle; tag toggles.
- Non-matching responses, and any response in Idle: consumed and dropped, with no r_valid.
- Timeout (TimeoutCycles>0): the counter increments each Outstanding cycle. When it reaches TimeoutCycles-1 without a match:
  - r_valid=1, err=1, rdata=0.
  - Next state Idle; tag toggles, so a late response mismatches and is dropped.
- Match and timeout in the same cycle: the match wins and err follows d_error.
- dmactive_i low:
  - In Idle: no a_valid, gnt stays 0.
  - In Outstanding: immediate abort to Idle, tag toggle, no r_valid pulse.
- Granted SBA request back-to-back: a new gnt is possible in the cycle after r_valid.
- Asynchronous reset mid-transaction: returns to Idle. A response arriving after reset with tag 0 may match a new request. This is accepted, because the crossbar is reset in the same domain.

Decomposition:
- Shared package (dm_pkg): TL-UL opcode constants (Get, PutFullData, PutPartialData, AccessAck, AccessAckData) and the state encoding (Idle=0, Outstanding=1).
- No sub-module. The timeout counter is inline.

Test Plan:
- Read: req, add=0x1000_0006, we=0, a_ready=1 -> same-cycle gnt, Get, address 0x1000_0004, mask 0xF, source {SourceBase,0}. AccessAckData data=0xDEADBEEF two cycles later -> r_valid pulse, rdata=0xDEADBEEF, err=0.
- Write: be=0xF gives PutFullData; be=0x3 gives PutPartialData with mask 0x3. AccessAck -> r_valid, rdata=0, tag toggles to 1.
- Backpressure: a_ready low for 3 cycles -> a_valid held, gnt only in the a_ready cycle, fields stable throughout.
- Timeout: TimeoutCycles=8, no D response -> r_valid with err=1 exactly 8 cycles after gnt. A late response with the old tag is dropped with no r_valid.
- Error and stray responses: d_error=1 gives err=1. A d_valid with a wrong source while Outstanding -> dropped, state remains Outstanding.
- Abort: dmactive_i deasserted while Outstanding -> Idle next cycle with no r_valid. Reset asserted mid-transaction -> all outputs return to their reset values asynchronously.
